mem_arbiter: RTL
================

# mem_arbiter

Parametrised successor to the single-client byte-serial memory controller. Arbitrates `NUM_PORTS` request channels (instruction fetch, load/store buffer, …) onto the single 8-bit RAM/IO bus. Adds:
- round-robin fairness;
- registered, sign-extended read data;
- IO-write back-pressure;
- a `clear` input that aborts in-flight reads on pipeline flush.

Sits between the cache/LSB front ends and the top-level `mem_*` pins.

## Interface
- `NUM_PORTS`, default 2: number of request channels, ≥1.
- `PTR_W`, default `$clog2(NUM_PORTS)` (min 1): width of grant index.
- `clk` in 1: single clock, posedge.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: global enable; when low, all state is frozen.
- `clear` in 1: flush; aborts in-flight and newly requested reads.
- `p_valid` in `NUM_PORTS`: per-port request, held until matching `p_ready`.
- `p_wr` in `NUM_PORTS`: 1 = write.
- `p_addr` in `32*NUM_PORTS`: packed, port i at `[32i+31:32i]`.
- `p_type` in `3*NUM_PORTS`: `[1:0]` 00 byte, 01 half, 10 word; `[2]` 1 = sign-extend the read.
- `p_wdata` in `32*NUM_PORTS`: write data, little-endian.
- `p_ready` out `NUM_PORTS`: one-cycle completion pulse, one-hot.
- `p_rdata` out 32: read result, valid while `p_ready` is high; shared by all ports.
- `mem_din` in 8: RAM read data, one cycle after its address.
- `mem_dout` out 8: write byte.
- `mem_a` out 32: byte address.
- `mem_wr` out 1: 1 = write.
- `io_buffer_full` in 1: UART transmit buffer full.

## Operation
- States: IDLE, XFER, DRAIN, DONE.
- **IDLE:**
  - Scan `p_valid`, starting at `(last_grant+1) mod NUM_PORTS`; the first set bit wins.
  - When `clear`=1, reads are masked out of the scan.
  - On a win, latch addr/type/wdata/wr and the index into `cur`, set byte counter `k`=0, set `n` = 1/2/4 from `type[1:0]` (`type[1:0]`=11 is treated as word), update `last_grant`, go to XFER.
- **XFER:**
  - Each cycle drive `mem_a`=addr+k and `mem_wr`=wr.
  - For writes, `mem_dout`=wdata byte k.
  - When `k`=n-1: write → DONE; read → DRAIN. Otherwise increment `k`.
- **DRAIN** (reads only): capture the final `mem_din` byte, then go to DONE.
- **Read capture:** `mem_din` in the cycle after address k is stored to result byte k.
- **DONE:**
  - Pulse `p_ready[cur]`.
  - `p_rdata` = result, zero- or sign-extended from bit 7 or 15 per `type`.
  - Return to IDLE. The next grant may occur in the following cycle.
- **IO space** (`addr[17:16]`=2'b11):
  - Address never increments.
  - Writes: byte k is issued only in a cycle where `io_buffer_full`=0; otherwise XFER stalls with `mem_wr`=0 and `k` held.
  - IO reads are byte-only; a larger type is executed as a byte.
- **`clear`:**
  - If `clear`=1 while `cur` is a read in XFER/DRAIN/DONE, go to IDLE next cycle with no `p_ready` pulse.
  - Writes always complete regardless of `clear`.
- **`mem_wr` and `mem_dout`:** `mem_wr`=0 in IDLE, DRAIN, DONE and during stalls. `mem_dout`=0 whenever `mem_wr`=0.
- **Protocol:** a requester must drop `p_valid` in the cycle after `p_ready`, or present a new request.

## Timing
- **Reset:**
  - Regs: state=IDLE, `last_grant`=`NUM_PORTS`-1 (so port 0 wins first), `k`=0.
  - Outputs: `p_ready`=0, `p_rdata`=0, `mem_a`=0, `mem_dout`=0, `mem_wr`=0.
- `rst` has priority over `rdy` and `clear`.
- **Grant cycle G** (IDLE with a winner): no bus activity.
- **Write, n bytes, non-IO:** addresses at G+1..G+n; `p_ready` at G+n+1. Latency n+1.
- **Read, n bytes:**
  - Addresses at G+1..G+n; data sampled at G+2..G+n+1.
  - `p_ready` at G+n+2. Latency n+2.
- **IO write:** each stall cycle adds one.
- **`rdy`=0:** state, counters and outputs all hold. `mem_wr` is forced 0 and no `mem_din` is sampled. A RAM read that was in flight is reissued when `rdy` returns.
- **Back-to-back throughput:** word write every 6 cycles; word read every 7.

## Test plan
- **Reset then word write:** port0 writes 0xDDCCBBAA to 0x100 → `mem_a` 0x100..0x103 over G+1..G+4 with `mem_dout` AA,BB,CC,DD; `p_ready[0]` at G+5.
- **Signed half read:** RAM[0x200]=0x34, RAM[0x201]=0xF2; port1 type 101 → `p_rdata`=0xFFFFF234 with `p_ready[1]` at G+4. Same with type 001 → 0x0000F234.
- **Fairness:** both ports valid continuously with byte reads → grants alternate 0,1,0,1; neither port is granted twice in a row.
- **IO back-pressure:** port0 byte write 0x41 to 0x30000 with `io_buffer_full` high for 3 cycles → `mem_wr` low for 3 cycles, then a single write of 0x41; `p_ready` 3 cycles later than nominal.
- **Flush:** port1 word read; `clear` at G+2 → no `p_ready[1]`; IDLE at G+3; the pending port0 write is granted next.
- **`rdy` gating:** drop `rdy` for 2 cycles mid word-read → result identical and latency extended by exactly 2.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of NUM_PORTS request channels
// onto the single byte-serial RAM/IO bus.
module mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    clear,
  input  logic [NUM_PORTS-1:0]    p_valid,
  input  logic [NUM_PORTS-1:0]    p_wr,
  input  logic [32*NUM_PORTS-1:0] p_addr,
  input  logic [3*NUM_PORTS-1:0]  p_type,
  input  logic [32*NUM_PORTS-1:0] p_wdata,
  output logic [NUM_PORTS-1:0]    p_ready,
  output logic [31:0]             p_rdata,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);
  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

  state_t               state;
  logic [PTR_W-1:0]     last_grant;
  logic [PTR_W-1:0]     cur;
  logic [31:0]          addr;
  logic [31:0]          wdata;
  logic [2:0]           typ;
  logic                 wr;
  logic                 io;
  logic [1:0]           k;
  logic [1:0]           last_k;
  logic [31:0]          res;
  logic [31:0]          a_q;
  logic [31:0]          a_last;
  logic                 wr_q;
  logic [7:0]           dout_q;
  logic [NUM_PORTS-1:0] ready_q;

  logic [NUM_PORTS-1:0] cand;
  logic                 found;
  logic [PTR_W-1:0]     win;
  logic [31:0]          s_addr;
  logic [31:0]          s_wdata;
  logic [2:0]           s_type;
  logic [2:0]           s_typ;
  logic                 s_wr;
  logic                 s_io;
  logic [1:0]           s_last;
  logic [NUM_PORTS-1:0] cur_oh;
  logic [1:0]           nk;
  logic [1:0]           cap_idx;
  logic [7:0]           nbyte;
  logic [31:0]          res_n;
  logic [31:0]          ext;
  logic                 stall;
  logic                 flush;
  logic                 pend;

  // two passes give the rotated priority starting after last_grant
  always_comb begin
    cand  = p_valid & (clear ? p_wr : '1);
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && cand[i] && i > int'(last_grant)) begin
        found = 1'b1;
        win   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && cand[i] && i <= int'(last_grant)) begin
        found = 1'b1;
        win   = PTR_W'(i);
      end
    end
  end

  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_type  = '0;
    s_wr    = 1'b0;
    cur_oh  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win == PTR_W'(i)) begin
        s_addr  = p_addr[32*i +: 32];
        s_wdata = p_wdata[32*i +: 32];
        s_type  = p_type[3*i +: 3];
        s_wr    = p_wr[i];
      end
      cur_oh[i] = (cur == PTR_W'(i));
    end
    s_io  = (s_addr[17:16] == 2'b11);
    s_typ = (s_io && !s_wr) ? {s_type[2], 2'b00} : s_type;
    case (s_typ[1:0])
      2'b00:   s_last = 2'd0;
      2'b01:   s_last = 2'd1;
      default: s_last = 2'd3;
    endcase
  end

  always_comb begin
    nk      = k + 2'd1;
    nbyte   = 8'h00;
    cap_idx = (state == DRAIN) ? last_k : k - 2'd1;
    res_n   = res;
    for (int b = 0; b < 4; b++) begin
      if (nk == 2'(b)) nbyte = wdata[8*b +: 8];
      if (cap_idx == 2'(b)) res_n[8*b +: 8] = mem_din;
    end
    case (typ[1:0])
      2'b00:   ext = {{24{typ[2] & res_n[7]}}, res_n[7:0]};
      2'b01:   ext = {{16{typ[2] & res_n[15]}}, res_n[15:0]};
      default: ext = res_n;
    endcase
  end

  assign stall = (state == XFER) && wr && io && io_buffer_full;
  assign flush = clear && !wr;
  assign pend  = !wr && ((state == XFER && k != 2'd0) || state == DRAIN);

  // while frozen, keep the unsampled read's address on the bus
  assign mem_a    = (!rdy && pend) ? a_last : a_q;
  assign mem_wr   = wr_q && rdy && !stall;
  assign mem_dout = mem_wr ? dout_q : 8'h00;
  assign p_ready  = ready_q & {NUM_PORTS{!flush}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= PTR_W'(NUM_PORTS - 1);
      cur        <= '0;
      addr       <= '0;
      wdata      <= '0;
      typ        <= '0;
      wr         <= 1'b0;
      io         <= 1'b0;
      k          <= 2'd0;
      last_k     <= 2'd0;
      res        <= '0;
      a_q        <= '0;
      a_last     <= '0;
      wr_q       <= 1'b0;
      dout_q     <= 8'h00;
      ready_q    <= '0;
      p_rdata    <= '0;
    end else if (rdy) begin
      ready_q <= '0;
      a_last  <= a_q;
      unique case (state)
        IDLE: begin
          if (found) begin
            state      <= XFER;
            cur        <= win;
            last_grant <= win;
            addr       <= s_addr;
            wdata      <= s_wdata;
            typ        <= s_typ;
            wr         <= s_wr;
            io         <= s_io;
            k          <= 2'd0;
            last_k     <= s_last;
            res        <= '0;
            a_q        <= s_addr;
            wr_q       <= s_wr;
            dout_q     <= s_wr ? s_wdata[7:0] : 8'h00;
          end
        end
        XFER: begin
          if (flush) begin
            state  <= IDLE;
            wr_q   <= 1'b0;
            dout_q <= 8'h00;
          end else if (!stall) begin
            if (!wr && k != 2'd0) res <= res_n;
            if (k == last_k) begin
              wr_q    <= 1'b0;
              dout_q  <= 8'h00;
              state   <= wr ? DONE : DRAIN;
              ready_q <= wr ? cur_oh : '0;
            end else begin
              k      <= nk;
              a_q    <= io ? addr : addr + {30'd0, nk};
              dout_q <= wr ? nbyte : 8'h00;
            end
          end
        end
        DRAIN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            res     <= res_n;
            p_rdata <= ext;
            ready_q <= cur_oh;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
